cic_readout_ctrl: RTL

Readout scheduler between the CIC3 decimation filter output and the off-chip serial link.
- Runs on the 81.92 MHz serializer clock.
- Counts sclk sample strobes from the echip clock generator and captures one filter word every N strobes (runtime-programmable output decimation).
- Shifts each captured word out MSB-first with a frame qualifier.
- Flags overrun when a capture is due while a previous word is still shifting.

---
 rtl/echip_readout_pkg.sv | 19 +
 rtl/readout_decim_counter.sv | 52 +++++
 rtl/cic_readout_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/echip_readout_pkg.sv
// Purpose: shared types and constants for the CIC3 readout scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package echip_readout_pkg;

    // Readout scheduler states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2
    } rd_state_e;

    // Width of the CIC3 filter output word and of one serial frame
    localparam int CIC_OUT_W = 25;

    // Serializer clocks per sclk period (spacing of sample_strobe pulses)
    localparam int SCLK_DIV = 16;

endpackage

// File: rtl/readout_decim_counter.sv
// Purpose: counts sample strobes and flags every Nth one as a capture; N latched on arm, 0 means 2^RATIO_W.
// Latency: capture_due is combinational with the strobe; counter state updates on the next clk edge.
// Backpressure: none; counting never stalls, so the decimation phase survives busy frames.
module readout_decim_counter
    import echip_readout_pkg::*;
#(
    parameter int RATIO_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               arm,
    input  logic               count_en,
    input  logic               sample_strobe,
    input  logic [RATIO_W-1:0] decim_ratio,
    output logic               capture_due
);

    localparam logic [RATIO_W:0] RATIO_MAX = {1'b1, {RATIO_W{1'b0}}};
    localparam logic [RATIO_W:0] RATIO_ONE = {{RATIO_W{1'b0}}, 1'b1};

    // One extra bit so a programmed 0 can hold the full 2^RATIO_W
    logic [RATIO_W:0]   ratio_q, ratio_d;
    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic               due;

    // Capture is due on the strobe that completes the current ratio window
    always_comb begin
        due     = count_en && sample_strobe && ({1'b0, cnt_q} == (ratio_q - RATIO_ONE));
        ratio_d = ratio_q;
        cnt_d   = cnt_q;
        if (arm) begin
            ratio_d = (decim_ratio == '0) ? RATIO_MAX : {1'b0, decim_ratio};
            cnt_d   = '0;
        end else if (count_en && sample_strobe) begin
            cnt_d = due ? '0 : cnt_q + 1'b1;
        end
    end

    assign capture_due = due;

    // Ratio latch and strobe counter registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ratio_q <= '0;
            cnt_q   <= '0;
        end else begin
            ratio_q <= ratio_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/cic_readout_ctrl.sv
// Purpose: captures one CIC3 word every N sclk strobes and shifts it out MSB-first with a frame qualifier.
// Latency: first bit appears 1 clk after the capturing strobe; a frame lasts DATA_W clk.
// Backpressure: none; a capture due mid-frame is dropped and raises the sticky overrun flag.
module cic_readout_ctrl
    import echip_readout_pkg::*;
#(
    parameter int DATA_W  = CIC_OUT_W,
    parameter int RATIO_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [RATIO_W-1:0] decim_ratio,
    input  logic               sample_strobe,
    input  logic [DATA_W-1:0]  din,
    input  logic               clr_overrun,
    output logic               sdata,
    output logic               sframe,
    output logic               word_valid,
    output logic               busy,
    output logic               overrun
);

    localparam int              BCNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(DATA_W - 1);

    rd_state_e          state_q, state_d;
    logic [BCNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic               sdata_q, sdata_d;
    logic               sframe_q, sframe_d;
    logic               word_valid_q, word_valid_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;

    logic               arm;
    logic               count_en;
    logic               capture_due;
    logic               load;

    // Ratio is latched only when leaving IDLE; strobes in the disabling ARMED cycle are ignored
    assign arm      = (state_q == IDLE) && enable;
    assign count_en = ((state_q == ARMED) && enable) || (state_q == SHIFT);

    readout_decim_counter #(
        .RATIO_W (RATIO_W)
    ) u_decim_counter (
        .clk           (clk),
        .reset_n       (reset_n),
        .arm           (arm),
        .count_en      (count_en),
        .sample_strobe (sample_strobe),
        .decim_ratio   (decim_ratio),
        .capture_due   (capture_due)
    );

    // Next-state and next-output logic; every output is taken from a flop
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        sdata_d      = 1'b0;
        sframe_d     = 1'b0;
        word_valid_d = 1'b0;
        overrun_d    = overrun_q && !clr_overrun;
        load         = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (capture_due) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_cnt_q != '0) begin
                    // Mid-frame: keep shifting; a capture landing here is lost
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    shreg_d   = shreg_q << 1;
                    sdata_d   = shreg_q[DATA_W-2];
                    sframe_d  = 1'b1;
                    if (capture_due) begin
                        overrun_d = 1'b1;
                    end
                end else if (!enable) begin
                    // Disabled while the last bit goes out: finish and park, any coincident capture is discarded
                    state_d = IDLE;
                end else if (capture_due) begin
                    // Capture on the last bit chains straight into the next frame
                    load = 1'b1;
                end else begin
                    state_d = ARMED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            state_d      = SHIFT;
            shreg_d      = din;
            bit_cnt_d    = LAST_IDX;
            sdata_d      = din[DATA_W-1];
            sframe_d     = 1'b1;
            word_valid_d = 1'b1;
        end
    end

    assign busy_d = (state_d == SHIFT);

    // FSM, shifter and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            sdata_q      <= 1'b0;
            sframe_q     <= 1'b0;
            word_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            sdata_q      <= sdata_d;
            sframe_q     <= sframe_d;
            word_valid_q <= word_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign sdata      = sdata_q;
    assign sframe     = sframe_q;
    assign word_valid = word_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule
